id_issue_front: RTL and testbench

Parametrised ID-stage front end for the five-stage MIPS core. It sits between IF and the decoder/EX, and owns four jobs:
- the IF→ID pipeline register, with a valid/ready handshake;
- capture and replay of the synchronous inst SRAM read data across any stall length;
- generalised N-source operand forwarding with `$0` exclusion;
- a decoder-qualified load-use interlock.

It also keeps a saturating hazard-stall performance counter.

---
 rtl/id_issue_front.sv | 149 ++++++++++++++
 tb/tb_id_issue_front.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/id_issue_front.sv
// id_issue_front: ID-stage front end for the five-stage MIPS core.
//   - IF->ID pipeline register with valid/ready handshake
//   - capture/replay of sync inst SRAM read data across stalls
//   - N-source operand forwarding (index 0 youngest), $0 excluded
//   - decoder-qualified load-use interlock + saturating stall counter
// Ports:
//   clk, rst (sync, active-high), flush
//   if_valid/if_pc/if_ready        : fetch handshake
//   inst_sram_rdata                : SRAM data, one cycle after accept
//   ex_ready                       : EX accepts the ID instruction
//   id_valid/id_pc/id_inst         : ID instruction (inst=0 when empty)
//   dec_use_rs/dec_use_rt          : decoder operand-use qualifiers
//   rf_rdata1/rf_rdata2            : regfile data for rs/rt
//   fwd_we/fwd_waddr/fwd_wdata/fwd_load : per-source forwarding bus
//   rs_data/rt_data                : forwarded operands
//   hazard, stall_cnt              : load-use stall and its counter

// One operand's forwarding mux: lowest-index matching source wins.
module id_fwd_sel #(
  parameter int NUM_FWD    = 3,
  parameter int LOAD_READY = 1
) (
  input  logic [4:0]            raddr,
  input  logic [31:0]           rf_rdata,
  input  logic [NUM_FWD-1:0]    fwd_we,
  input  logic [NUM_FWD*5-1:0]  fwd_waddr,
  input  logic [NUM_FWD*32-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]    fwd_load,
  output logic [31:0]           data,
  output logic                  load_wait
);
  // Walk oldest to youngest so the youngest match overwrites last.
  always_comb begin
    data      = rf_rdata;
    load_wait = 1'b0;
    for (int i = NUM_FWD-1; i >= 0; i--) begin
      if (fwd_we[i] && (fwd_waddr[5*i +: 5] == raddr) && (raddr != 5'd0)) begin
        data      = fwd_wdata[32*i +: 32];
        load_wait = fwd_load[i] && (i < LOAD_READY);
      end
    end
  end
endmodule

module id_issue_front #(
  parameter int PC_W       = 32,
  parameter int NUM_FWD    = 3,
  parameter int LOAD_READY = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  if_valid,
  input  logic [PC_W-1:0]       if_pc,
  output logic                  if_ready,
  input  logic [31:0]           inst_sram_rdata,
  input  logic                  ex_ready,
  output logic                  id_valid,
  output logic [PC_W-1:0]       id_pc,
  output logic [31:0]           id_inst,
  input  logic                  dec_use_rs,
  input  logic                  dec_use_rt,
  input  logic [31:0]           rf_rdata1,
  input  logic [31:0]           rf_rdata2,
  input  logic [NUM_FWD-1:0]    fwd_we,
  input  logic [NUM_FWD*5-1:0]  fwd_waddr,
  input  logic [NUM_FWD*32-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]    fwd_load,
  output logic [31:0]           rs_data,
  output logic [31:0]           rt_data,
  output logic                  hazard,
  output logic [CNT_W-1:0]      stall_cnt
);
  // Instruction source: LIVE = SRAM output this cycle, HELD = captured copy.
  typedef enum logic [1:0] {S_EMPTY, S_LIVE, S_HELD} state_t;

  state_t      state, state_nxt;
  logic [31:0] hold_r;
  logic        fire, accept;

  logic [1:0][4:0]  raddr;
  logic [1:0][31:0] rf_rd;
  logic [1:0][31:0] opnd;
  logic [1:0]       load_wait;
  logic [1:0]       use_r;

  assign id_valid = (state != S_EMPTY);

  always_comb begin
    case (state)
      S_LIVE:  id_inst = inst_sram_rdata;
      S_HELD:  id_inst = hold_r;
      default: id_inst = 32'd0;
    endcase
  end

  // Port 0 = rs, port 1 = rt.
  assign raddr = {id_inst[20:16], id_inst[25:21]};
  assign rf_rd = {rf_rdata2, rf_rdata1};
  assign use_r = {dec_use_rt, dec_use_rs};

  for (genvar p = 0; p < 2; p++) begin : g_port
    id_fwd_sel #(.NUM_FWD(NUM_FWD), .LOAD_READY(LOAD_READY)) u_sel (
      .raddr     (raddr[p]),
      .rf_rdata  (rf_rd[p]),
      .fwd_we    (fwd_we),
      .fwd_waddr (fwd_waddr),
      .fwd_wdata (fwd_wdata),
      .fwd_load  (fwd_load),
      .data      (opnd[p]),
      .load_wait (load_wait[p])
    );
  end

  assign rs_data = opnd[0];
  assign rt_data = opnd[1];

  assign hazard   = id_valid & |(use_r & load_wait);
  assign fire     = id_valid & ~hazard & ex_ready;
  assign if_ready = ~id_valid | fire;
  assign accept   = if_valid & if_ready & ~flush;

  always_comb begin
    state_nxt = state;
    if (flush)                           state_nxt = S_EMPTY;
    else if (accept)                     state_nxt = S_LIVE;
    else if (fire)                       state_nxt = S_EMPTY;
    else if (state == S_LIVE)            state_nxt = S_HELD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_EMPTY;
      hold_r    <= 32'd0;
      id_pc     <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      // SRAM output is only valid for one cycle; capture it on the first stall.
      if (state == S_LIVE && !fire && !flush)
        hold_r <= inst_sram_rdata;
      if (accept)
        id_pc <= if_pc;
      if (hazard && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
endmodule

// File: tb/tb_id_issue_front.sv
module tb_id_issue_front;
  localparam int PC_W = 32, NF = 3, CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, flush, if_valid, if_ready, ex_ready;
  logic [PC_W-1:0] if_pc, id_pc;
  logic [31:0]     inst_sram_rdata, id_inst, rf_rdata1, rf_rdata2, rs_data, rt_data;
  logic            id_valid, dec_use_rs, dec_use_rt, hazard;
  logic [NF-1:0]   fwd_we, fwd_load;
  logic [NF*5-1:0] fwd_waddr;
  logic [NF*32-1:0] fwd_wdata;
  logic [CW-1:0]   stall_cnt;

  id_issue_front #(.PC_W(PC_W), .NUM_FWD(NF), .LOAD_READY(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_pc(if_pc),
    .if_ready(if_ready), .inst_sram_rdata(inst_sram_rdata), .ex_ready(ex_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_load(fwd_load),
    .rs_data(rs_data), .rt_data(rt_data), .hazard(hazard), .stall_cnt(stall_cnt)
  );

  typedef enum int {V_VALID, V_INST, V_PC, V_IFRDY, V_HAZ, V_RS, V_RT, V_CNT} sel_t;
  typedef struct {sel_t sel; logic [31:0] exp; string name;} exp_t;

  exp_t exq[$];
  int   n_cmp = 0, n_bad = 0;

  task automatic expect_v(input sel_t s, input logic [31:0] v, input string nm);
    exp_t e;
    e.sel = s; e.exp = v; e.name = nm;
    exq.push_back(e);
  endtask

  function automatic logic [31:0] observe(input sel_t s);
    case (s)
      V_VALID: return {31'd0, id_valid};
      V_INST:  return id_inst;
      V_PC:    return id_pc;
      V_IFRDY: return {31'd0, if_ready};
      V_HAZ:   return {31'd0, hazard};
      V_RS:    return rs_data;
      V_RT:    return rt_data;
      default: return {{(32-CW){1'b0}}, stall_cnt};
    endcase
  endfunction

  // Monitor: drains all expectations queued for this cycle at the falling edge.
  always @(negedge clk) begin
    while (exq.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = exq.pop_front();
      a = observe(e.sel);
      n_cmp++;
      if (a !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.exp);
      end
    end
  end

  // Advance to just after the next rising edge; inputs set after this hold for the cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fwd_clear();
    fwd_we = '0; fwd_load = '0; fwd_waddr = '0; fwd_wdata = '0;
  endtask

  localparam logic [31:0] ADD_8_9 = 32'h01095020; // rs=8, rt=9
  localparam logic [31:0] R0_INST = 32'h00004020; // rs=0, rt=0

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; flush = 0; if_valid = 0; if_pc = '0; ex_ready = 0;
    inst_sram_rdata = 0; dec_use_rs = 0; dec_use_rt = 0;
    rf_rdata1 = 32'hAAAA0001; rf_rdata2 = 32'hBBBB0002;
    fwd_clear();

    // Reset
    cyc();
    expect_v(V_VALID, 0, "rst_valid"); expect_v(V_INST, 0, "rst_inst");
    expect_v(V_HAZ, 0, "rst_haz");     expect_v(V_IFRDY, 1, "rst_ifrdy");
    expect_v(V_CNT, 0, "rst_cnt");     expect_v(V_PC, 0, "rst_pc");

    // Stream A..D
    cyc(); rst = 0; if_valid = 1; ex_ready = 1; if_pc = 32'hBFC00000;
    expect_v(V_VALID, 0, "str_empty");
    for (int k = 0; k < 4; k++) begin
      cyc();
      if_pc = 32'hBFC00004 + 32'(4*k);
      if_valid = (k < 3);
      inst_sram_rdata = 32'hA0000000 + 32'(k);
      expect_v(V_VALID, 1, "str_valid");
      expect_v(V_INST, 32'hA0000000 + 32'(k), "str_inst");
      expect_v(V_PC, 32'hBFC00000 + 32'(4*k), "str_pc");
      expect_v(V_HAZ, 0, "str_haz");
      expect_v(V_IFRDY, 1, "str_ifrdy");
    end
    cyc(); expect_v(V_VALID, 0, "str_drain"); expect_v(V_INST, 0, "str_drain_inst");

    // Long stall replay
    cyc(); if_valid = 1; if_pc = 32'h100; ex_ready = 0;
    cyc(); if_valid = 0; inst_sram_rdata = 32'h3C010001;
    expect_v(V_INST, 32'h3C010001, "hold_live"); expect_v(V_PC, 32'h100, "hold_pc");
    expect_v(V_IFRDY, 0, "hold_ifrdy");
    for (int k = 0; k < 4; k++) begin
      cyc(); inst_sram_rdata = 32'hDEADBEEF;
      expect_v(V_VALID, 1, "hold_valid"); expect_v(V_INST, 32'h3C010001, "hold_inst");
    end
    cyc(); ex_ready = 1;
    expect_v(V_INST, 32'h3C010001, "hold_fire_inst"); expect_v(V_IFRDY, 1, "hold_fire_rdy");
    cyc(); ex_ready = 0; expect_v(V_VALID, 0, "hold_done");

    // Forward priority
    if_valid = 1; if_pc = 32'h200;
    cyc(); if_valid = 0; inst_sram_rdata = ADD_8_9;
    fwd_we = 3'b111; fwd_waddr = {5'd8, 5'd8, 5'd8};
    fwd_wdata = {32'h33, 32'h22, 32'h11};
    expect_v(V_RS, 32'h11, "fwd_src0"); expect_v(V_RT, 32'hBBBB0002, "fwd_rt_rf");
    expect_v(V_HAZ, 0, "fwd_nohaz");
    cyc(); fwd_we = 3'b110;
    expect_v(V_RS, 32'h22, "fwd_src1"); expect_v(V_INST, ADD_8_9, "fwd_inst_held");
    cyc(); fwd_clear(); ex_ready = 1; if_valid = 1; if_pc = 32'h204;
    expect_v(V_IFRDY, 1, "fwd_b2b_rdy");
    cyc(); if_valid = 0; ex_ready = 0; inst_sram_rdata = R0_INST;
    fwd_we = 3'b111; fwd_waddr = '0; fwd_wdata = {32'h33, 32'h22, 32'h11}; fwd_load = 3'b001;
    dec_use_rs = 1; dec_use_rt = 1; rf_rdata1 = 32'h12345678;
    expect_v(V_RS, 32'h12345678, "fwd_r0"); expect_v(V_HAZ, 0, "fwd_r0_nohaz");
    expect_v(V_PC, 32'h204, "fwd_pc");

    // Load-use
    cyc(); fwd_clear(); dec_use_rs = 0; dec_use_rt = 0; ex_ready = 1; if_valid = 1; if_pc = 32'h208;
    cyc(); if_valid = 0; ex_ready = 0; inst_sram_rdata = ADD_8_9;
    fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd9}; fwd_wdata = {64'd0, 32'h77}; fwd_load = 3'b001;
    expect_v(V_HAZ, 0, "lu_unused");
    cyc(); dec_use_rt = 1; ex_ready = 1;
    expect_v(V_HAZ, 1, "lu_haz"); expect_v(V_IFRDY, 0, "lu_ifrdy");
    expect_v(V_RT, 32'h77, "lu_rt_win"); expect_v(V_CNT, 0, "lu_cnt0");
    cyc(); fwd_we = 3'b010; fwd_waddr = {5'd0, 5'd9, 5'd0}; fwd_wdata = {32'd0, 32'hCAFE0009, 32'd0};
    fwd_load = 3'b010;
    expect_v(V_HAZ, 0, "lu_ok"); expect_v(V_RT, 32'hCAFE0009, "lu_rt_data");
    expect_v(V_CNT, 1, "lu_cnt1"); expect_v(V_IFRDY, 1, "lu_fire");
    cyc(); fwd_clear(); dec_use_rt = 0; ex_ready = 0;
    expect_v(V_VALID, 0, "lu_done");

    // Flush
    if_valid = 1; if_pc = 32'h300;
    cyc(); if_valid = 0; inst_sram_rdata = 32'h11111111;
    cyc(); inst_sram_rdata = 32'h22222222; expect_v(V_INST, 32'h11111111, "fl_held");
    cyc(); if_valid = 1; if_pc = 32'h304; ex_ready = 1; flush = 1;
    expect_v(V_IFRDY, 1, "fl_ifrdy");
    cyc(); flush = 0; if_valid = 0; ex_ready = 0;
    expect_v(V_VALID, 0, "fl_valid"); expect_v(V_INST, 0, "fl_inst");
    expect_v(V_PC, 32'h300, "fl_pc_kept");

    // Saturation (counter starts at 1)
    if_valid = 1; if_pc = 32'h400;
    cyc(); if_valid = 0; ex_ready = 1; inst_sram_rdata = ADD_8_9; dec_use_rt = 1;
    fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd9}; fwd_load = 3'b001;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) cyc();
      inst_sram_rdata = (k == 0) ? ADD_8_9 : 32'hDEADBEEF;
      expect_v(V_HAZ, 1, "sat_haz");
      expect_v(V_CNT, (1 + k > 15) ? 32'd15 : 32'(1 + k), "sat_cnt");
    end
    cyc(); expect_v(V_CNT, 15, "sat_full"); expect_v(V_INST, ADD_8_9, "sat_inst_held");
    cyc(); rst = 1;
    cyc(); rst = 0; fwd_clear(); dec_use_rt = 0; ex_ready = 0;
    expect_v(V_CNT, 0, "sat_rst_cnt"); expect_v(V_VALID, 0, "sat_rst_valid");
    expect_v(V_HAZ, 0, "sat_rst_haz");

    @(negedge clk);
    #1;
    if (exq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
